exu_wb_arb: RTL and testbench



---
 rtl/exu_wb_pkg.sv | 26 ++
 rtl/exu_wb_if.sv | 57 +++++
 rtl/exu_wb_arb_rr3.sv | 56 +++++
 rtl/exu_wb_arb.sv | 100 ++++++++++
 tb/tb_exu_wb_arb.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/exu_wb_pkg.sv
// Shared definitions for the execution-unit writeback arbiter:
// datapath widths, round-robin source indices and the result payload.
package exu_wb_pkg;

  localparam int REG_ADDR_WIDTH  = 5;
  localparam int REG_DATA_WIDTH  = 32;
  localparam int COMMIT_ID_WIDTH = 4;

  // Round-robin source order: MUL, DIV, LSU, then wrap.
  localparam int WB_SRC_MUL = 0;
  localparam int WB_SRC_DIV = 1;
  localparam int WB_SRC_LSU = 2;
  localparam int WB_RR_NUM  = 3;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0]  waddr;
    logic [REG_DATA_WIDTH-1:0]  wdata;
    logic [COMMIT_ID_WIDTH-1:0] commit_id;
  } wb_payload_t;

  // Next round-robin index after k; the unused encoding 3 folds to 0.
  function automatic logic [1:0] rr_next(input logic [1:0] k);
    rr_next = (k >= 2'd2) ? 2'd0 : k + 2'd1;
  endfunction

endpackage

// File: rtl/exu_wb_if.sv
// Result bus between the execution units and the writeback arbiter.
// Handshake: a multi-cycle source raises *_we_i with a payload and keeps
// both stable until it sees its *_ready_o high in the same cycle; that
// cycle is the transfer. The ALU has no ready and is always accepted.
interface exu_wb_if;
  import exu_wb_pkg::*;

  logic                       alu_we_i;
  logic [REG_ADDR_WIDTH-1:0]  alu_waddr_i;
  logic [REG_DATA_WIDTH-1:0]  alu_wdata_i;
  logic [COMMIT_ID_WIDTH-1:0] alu_commit_id_i;

  logic                       mul_we_i;
  logic [REG_ADDR_WIDTH-1:0]  mul_waddr_i;
  logic [REG_DATA_WIDTH-1:0]  mul_wdata_i;
  logic [COMMIT_ID_WIDTH-1:0] mul_commit_id_i;
  logic                       mul_ready_o;

  logic                       div_we_i;
  logic [REG_ADDR_WIDTH-1:0]  div_waddr_i;
  logic [REG_DATA_WIDTH-1:0]  div_wdata_i;
  logic [COMMIT_ID_WIDTH-1:0] div_commit_id_i;
  logic                       div_ready_o;

  logic                       lsu_we_i;
  logic [REG_ADDR_WIDTH-1:0]  lsu_waddr_i;
  logic [REG_DATA_WIDTH-1:0]  lsu_wdata_i;
  logic [COMMIT_ID_WIDTH-1:0] lsu_commit_id_i;
  logic                       lsu_ready_o;

  logic                       reg_we_o;
  logic [REG_ADDR_WIDTH-1:0]  reg_waddr_o;
  logic [REG_DATA_WIDTH-1:0]  reg_wdata_o;
  logic                       commit_valid_o;
  logic [COMMIT_ID_WIDTH-1:0] commit_id_o;

  // Source side (execution units / testbench)
  modport master (
    output alu_we_i, alu_waddr_i, alu_wdata_i, alu_commit_id_i,
    output mul_we_i, mul_waddr_i, mul_wdata_i, mul_commit_id_i,
    output div_we_i, div_waddr_i, div_wdata_i, div_commit_id_i,
    output lsu_we_i, lsu_waddr_i, lsu_wdata_i, lsu_commit_id_i,
    input  mul_ready_o, div_ready_o, lsu_ready_o,
    input  reg_we_o, reg_waddr_o, reg_wdata_o, commit_valid_o, commit_id_o
  );

  // Arbiter side
  modport slave (
    input  alu_we_i, alu_waddr_i, alu_wdata_i, alu_commit_id_i,
    input  mul_we_i, mul_waddr_i, mul_wdata_i, mul_commit_id_i,
    input  div_we_i, div_waddr_i, div_wdata_i, div_commit_id_i,
    input  lsu_we_i, lsu_waddr_i, lsu_wdata_i, lsu_commit_id_i,
    output mul_ready_o, div_ready_o, lsu_ready_o,
    output reg_we_o, reg_waddr_o, reg_wdata_o, commit_valid_o, commit_id_o
  );

endinterface

// File: rtl/exu_wb_arb_rr3.sv
// Three-requester round-robin arbiter. Grant is combinational from the
// request vector and the pointer; the pointer moves past the winner.
module wb_rr_arb3
  import exu_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_req,
  input  logic       i_en,
  output logic [2:0] o_gnt,
  output logic [1:0] o_ptr
);

  logic [1:0] r_ptr;
  logic [1:0] w_idx0;
  logic [1:0] w_idx1;
  logic [1:0] w_idx2;
  logic [1:0] w_nxt;
  logic [2:0] w_gnt;

  // Scan order starts at the pointer; encoding 3 is treated as 0.
  always_comb begin
    w_idx0 = (r_ptr == 2'd3) ? 2'd0 : r_ptr;
    w_idx1 = rr_next(w_idx0);
    w_idx2 = rr_next(w_idx1);
  end

  // Pick the first requester in scan order; only when enabled.
  always_comb begin
    w_gnt = 3'b000;
    w_nxt = w_idx0;
    if (i_req[w_idx0]) begin
      w_gnt[w_idx0] = i_en;
      w_nxt         = w_idx1;
    end else if (i_req[w_idx1]) begin
      w_gnt[w_idx1] = i_en;
      w_nxt         = w_idx2;
    end else if (i_req[w_idx2]) begin
      w_gnt[w_idx2] = i_en;
      w_nxt         = w_idx0;
    end
  end

  // Pointer advances only on an actual grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 2'd0;
    end else if (|w_gnt) begin
      r_ptr <= w_nxt;
    end
  end

  assign o_gnt = w_gnt;
  assign o_ptr = r_ptr;

endmodule

// File: rtl/exu_wb_arb.sv
// Writeback arbiter: ALU has absolute priority, MUL/DIV/LSU share the
// remaining slots round-robin. The winner's payload is registered onto
// the register-file write port and the commit report. Writes to x0 are
// suppressed but still reported as commits.
module exu_wb_arb
  import exu_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  exu_wb_if.slave    wb,
  output logic [1:0] dbg_rr_ptr_o
);

  logic [2:0]                 w_req;
  logic [2:0]                 w_gnt;
  logic                       w_en;
  logic                       w_any;
  wb_payload_t                w_pl;

  logic                       r_we;
  logic                       r_cv;
  logic [REG_ADDR_WIDTH-1:0]  r_waddr;
  logic [REG_DATA_WIDTH-1:0]  r_wdata;
  logic [COMMIT_ID_WIDTH-1:0] r_cid;

  assign w_req[WB_SRC_MUL] = wb.mul_we_i;
  assign w_req[WB_SRC_DIV] = wb.div_we_i;
  assign w_req[WB_SRC_LSU] = wb.lsu_we_i;

  // Reset forces all readies low regardless of requests.
  assign w_en = rst_n & ~wb.alu_we_i;

  wb_rr_arb3 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_req),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_ptr (dbg_rr_ptr_o)
  );

  assign wb.mul_ready_o = w_gnt[WB_SRC_MUL];
  assign wb.div_ready_o = w_gnt[WB_SRC_DIV];
  assign wb.lsu_ready_o = w_gnt[WB_SRC_LSU];

  assign w_any = wb.alu_we_i | (|w_gnt);

  // Select the granted payload; ALU overrides the round-robin grant.
  always_comb begin
    w_pl = '0;
    if (wb.alu_we_i) begin
      w_pl.waddr     = wb.alu_waddr_i;
      w_pl.wdata     = wb.alu_wdata_i;
      w_pl.commit_id = wb.alu_commit_id_i;
    end else if (w_gnt[WB_SRC_MUL]) begin
      w_pl.waddr     = wb.mul_waddr_i;
      w_pl.wdata     = wb.mul_wdata_i;
      w_pl.commit_id = wb.mul_commit_id_i;
    end else if (w_gnt[WB_SRC_DIV]) begin
      w_pl.waddr     = wb.div_waddr_i;
      w_pl.wdata     = wb.div_wdata_i;
      w_pl.commit_id = wb.div_commit_id_i;
    end else if (w_gnt[WB_SRC_LSU]) begin
      w_pl.waddr     = wb.lsu_waddr_i;
      w_pl.wdata     = wb.lsu_wdata_i;
      w_pl.commit_id = wb.lsu_commit_id_i;
    end
  end

  // Strobes pulse for one cycle per grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= 1'b0;
      r_cv <= 1'b0;
    end else begin
      r_we <= w_any && (w_pl.waddr != '0);
      r_cv <= w_any;
    end
  end

  // Payload registers load on grant and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr <= '0;
      r_wdata <= '0;
      r_cid   <= '0;
    end else if (w_any) begin
      r_waddr <= w_pl.waddr;
      r_wdata <= w_pl.wdata;
      r_cid   <= w_pl.commit_id;
    end
  end

  assign wb.reg_we_o       = r_we;
  assign wb.reg_waddr_o    = r_waddr;
  assign wb.reg_wdata_o    = r_wdata;
  assign wb.commit_valid_o = r_cv;
  assign wb.commit_id_o    = r_cid;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Testbench for exu_wb_arb: directed scenarios followed by random traffic,
// with a queue-based scoreboard and a reference model of the grant rules.
module tb_exu_wb_arb;
  import exu_wb_pkg::*;

  localparam int A = REG_ADDR_WIDTH;
  localparam int D = REG_DATA_WIDTH;
  localparam int C = COMMIT_ID_WIDTH;
  localparam int W = 1 + A + D + C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exu_wb_if wb();
  logic [1:0] dbg_ptr;

  exu_wb_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb           (wb.slave),
    .dbg_rr_ptr_o (dbg_ptr)
  );

  // ---------------- bench state ----------------
  logic [W-1:0] exp_q[$];
  int           gnt_log[$];
  int           vectors = 0;
  int           miscompares = 0;

  logic         alu_we;
  logic [A-1:0] alu_addr;
  logic [D-1:0] alu_data;
  logic [C-1:0] alu_cid;
  logic         src_req[3];
  logic [A-1:0] src_addr[3];
  logic [D-1:0] src_data[3];
  logic [C-1:0] src_cid[3];
  bit           refill = 0;
  int           m_ptr = 0;
  logic [W-1:0] hold = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic new_payload(input int k);
    src_addr[k] = A'($urandom_range(0, 31));
    src_data[k] = D'($urandom);
    src_cid[k]  = C'($urandom_range(0, 15));
  endtask

  // ---------------- driver ----------------
  task automatic drive_if();
    wb.alu_we_i = alu_we; wb.alu_waddr_i = alu_addr;
    wb.alu_wdata_i = alu_data; wb.alu_commit_id_i = alu_cid;
    wb.mul_we_i = src_req[0]; wb.mul_waddr_i = src_addr[0];
    wb.mul_wdata_i = src_data[0]; wb.mul_commit_id_i = src_cid[0];
    wb.div_we_i = src_req[1]; wb.div_waddr_i = src_addr[1];
    wb.div_wdata_i = src_data[1]; wb.div_commit_id_i = src_cid[1];
    wb.lsu_we_i = src_req[2]; wb.lsu_waddr_i = src_addr[2];
    wb.lsu_wdata_i = src_data[2]; wb.lsu_commit_id_i = src_cid[2];
  endtask

  // One cycle: apply inputs, predict the grant, check readies, queue result.
  task automatic step();
    int g;
    logic [2:0] exp_rdy;
    logic [2:0] act_rdy;
    @(negedge clk);
    drive_if();
    #1;
    g = -1;
    if (!alu_we) begin
      for (int i = 0; i < WB_RR_NUM; i++) begin
        int k;
        k = (m_ptr + i) % WB_RR_NUM;
        if (g < 0 && src_req[k]) g = k;
      end
    end
    exp_rdy = 3'b000;
    if (g >= 0) exp_rdy[g] = 1'b1;
    act_rdy = {wb.lsu_ready_o, wb.div_ready_o, wb.mul_ready_o};
    check("ready", 64'(act_rdy), 64'(exp_rdy));
    for (int k = 0; k < 3; k++) if (act_rdy[k]) gnt_log.push_back(k);
    if (alu_we) begin
      exp_q.push_back({alu_addr != 0, alu_addr, alu_data, alu_cid});
    end else if (g >= 0) begin
      exp_q.push_back({src_addr[g] != 0, src_addr[g], src_data[g], src_cid[g]});
      m_ptr = (g + 1) % WB_RR_NUM;
      if (refill) new_payload(g);
      else src_req[g] = 1'b0;
    end
    alu_we = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    act = {wb.reg_we_o, wb.reg_waddr_o, wb.reg_wdata_o, wb.commit_id_o};
    if (rst_n) begin
      if (wb.commit_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 64'(wb.commit_valid_o), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("writeback", 64'(act), 64'(e));
          hold = e;
        end
      end else begin
        check("idle_hold", 64'(act), 64'({1'b0, hold[W-2:0]}));
      end
    end
  end

  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_outputs", 64'({wb.reg_we_o, wb.commit_valid_o, wb.reg_waddr_o,
                              wb.reg_wdata_o, wb.commit_id_o}), 64'(0));
    check("rst_ready", 64'({wb.lsu_ready_o, wb.div_ready_o, wb.mul_ready_o}), 64'(0));
    exp_q.delete();
    hold = '0;
    m_ptr = 0;
    alu_we = 1'b0;
    for (int k = 0; k < 3; k++) src_req[k] = 1'b0;
    drive_if();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    alu_we = 1'b1; alu_addr = 5'd1; alu_data = '1; alu_cid = '1;
    for (int k = 0; k < 3; k++) begin
      src_req[k] = 1'b1;
      new_payload(k);
    end
    drive_if();
    #12;
    // Reset with requests present: everything stays at zero.
    check("reset_out", 64'({wb.reg_we_o, wb.commit_valid_o, wb.reg_waddr_o,
                            wb.reg_wdata_o, wb.commit_id_o}), 64'(0));
    check("reset_ready", 64'({wb.lsu_ready_o, wb.div_ready_o, wb.mul_ready_o}), 64'(0));
    check("reset_ptr", 64'(dbg_ptr), 64'(0));
    alu_we = 1'b0;
    for (int k = 0; k < 3; k++) src_req[k] = 1'b0;
    drive_if();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) step();

    // ALU alone
    alu_we = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234; alu_cid = 4'd3;
    step();
    @(posedge clk); #1;
    check("alu_write", 64'({wb.reg_we_o, wb.commit_valid_o, wb.reg_waddr_o,
                            wb.reg_wdata_o, wb.commit_id_o}),
          64'({1'b1, 1'b1, 5'd5, 32'h1234, 4'd3}));

    // ALU and MUL together: MUL waits one cycle
    alu_we = 1'b1; alu_addr = 5'd9; alu_data = 32'hAAAA; alu_cid = 4'd1;
    src_req[0] = 1'b1; src_addr[0] = 5'd7; src_data[0] = 32'h77; src_cid[0] = 4'd2;
    step();
    step();

    // LSU write to x0: commit reported, write suppressed
    src_req[2] = 1'b1; src_addr[2] = 5'd0; src_data[2] = 32'h55; src_cid[2] = 4'd9;
    step();
    @(posedge clk); #1;
    check("x0_commit", 64'({wb.reg_we_o, wb.commit_valid_o, wb.commit_id_o}),
          64'({1'b0, 1'b1, 4'd9}));

    // All three RR sources continuously requesting
    gnt_log.delete();
    refill = 1;
    for (int k = 0; k < 3; k++) begin
      src_req[k] = 1'b1;
      new_payload(k);
    end
    repeat (6) step();
    refill = 0;
    for (int k = 0; k < 3; k++) src_req[k] = 1'b0;
    check("rr_len", 64'(gnt_log.size()), 64'(6));
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      check("rr_order", 64'(gnt_log[i]), 64'(i % 3));

    // MUL only with pointer at 1: still MUL, pointer stays at 1
    src_req[0] = 1'b1; new_payload(0);
    step();
    @(posedge clk); #1;
    check("ptr_after_mul", 64'(dbg_ptr), 64'(1));
    src_req[0] = 1'b1; new_payload(0);
    step();
    @(posedge clk); #1;
    check("ptr_mul_again", 64'(dbg_ptr), 64'(1));

    // Random traffic with a reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) mid_reset();
      alu_we = ($urandom_range(0, 3) == 0);
      alu_addr = A'($urandom_range(0, 31));
      alu_data = D'($urandom);
      alu_cid  = C'($urandom_range(0, 15));
      for (int k = 0; k < 3; k++) begin
        if (!src_req[k] && $urandom_range(0, 1) == 1) begin
          src_req[k] = 1'b1;
          new_payload(k);
        end
      end
      step();
    end

    // Drain outstanding requests, bounded
    for (int n = 0; n < 20; n++) begin
      if (!src_req[0] && !src_req[1] && !src_req[2]) break;
      step();
    end
    repeat (2) step();
    check("drain_queue", 64'(exp_q.size()), 64'(0));
    check("drain_req", 64'({src_req[2], src_req[1], src_req[0]}), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
